id_rf_read_seq: RTL and testbench

//  Sequences operand fetch for the ID stage over ONE shared register-file read port.

---
 rtl/id_rf_read_seq_pkg.sv | 27 ++
 rtl/id_rf_read_seq.sv | 153 +++++++++++++++
 tb/tb_id_rf_read_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_rf_read_seq_pkg.sv
// ============================================================================
// Module : id_rf_read_seq_pkg
// Brief  : Shared types and defaults for the ID-stage operand read sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_rf_read_seq_pkg;

  localparam int REG_W_DEFAULT  = 64;
  localparam int ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    RDSEQ_IDLE = 2'd0,
    RDSEQ_RD1  = 2'd1,
    RDSEQ_RD2  = 2'd2,
    RDSEQ_DONE = 2'd3
  } rdseq_state_e;

  // First state after an accept: skip straight past sources that never touch the port.
  function automatic rdseq_state_e first_state(input logic need1, input logic need2);
    return need1 ? RDSEQ_RD1 : (need2 ? RDSEQ_RD2 : RDSEQ_DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_rf_read_seq.sv
// ============================================================================
// Module : id_rf_read_seq
// Brief  : Serialises rs1/rs2 fetch over one regfile read port, hands operands
//          to EX through a valid/ready handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_rf_read_seq
  import id_rf_read_seq_pkg::*;
#(
  parameter int REG_W  = REG_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rs1_r_ena,
  input  logic [ADDR_W-1:0] rs1_r_addr,
  input  logic              rs2_r_ena,
  input  logic [ADDR_W-1:0] rs2_r_addr,
  output logic              rf_r_ena,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [REG_W-1:0]  rf_r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  op1_src,
  output logic [REG_W-1:0]  op2_src,
  output logic              busy
);

  rdseq_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic              need1_q, need1_d;
  logic              need2_q, need2_d;
  logic [REG_W-1:0]  op1_q, op1_d;
  logic [REG_W-1:0]  op2_q, op2_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              rf_r_ena_q, rf_r_ena_d;
  logic [ADDR_W-1:0] rf_r_addr_q, rf_r_addr_d;

  logic w_in_ready;
  logic w_accept;
  logic w_new_need1;
  logic w_new_need2;

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign w_in_ready  = rst & ((state_q == RDSEQ_IDLE) | ((state_q == RDSEQ_DONE) & out_ready));
  assign w_accept    = in_valid & w_in_ready & ~flush;
  assign w_new_need1 = rs1_r_ena & (rs1_r_addr != '0);
  assign w_new_need2 = rs2_r_ena & (rs2_r_addr != '0);

  always_comb begin
    state_d    = state_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    need1_d    = need1_q;
    need2_d    = need2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;

    case (state_q)
      RDSEQ_RD1: begin
        op1_d   = rf_r_data;
        state_d = need2_q ? RDSEQ_RD2 : RDSEQ_DONE;
      end
      RDSEQ_RD2: begin
        op2_d   = rf_r_data;
        state_d = RDSEQ_DONE;
      end
      RDSEQ_DONE: begin
        if (out_ready) state_d = RDSEQ_IDLE;
      end
      default: ;
    endcase

    // An accept in DONE replaces the handshake exit, giving back-to-back issue.
    if (w_accept) begin
      rs1_addr_d = rs1_r_addr;
      rs2_addr_d = rs2_r_addr;
      need1_d    = w_new_need1;
      need2_d    = w_new_need2;
      op1_d      = '0;
      op2_d      = '0;
      state_d    = first_state(w_new_need1, w_new_need2);
    end

    if (flush) begin
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      need1_d    = 1'b0;
      need2_d    = 1'b0;
      op1_d      = '0;
      op2_d      = '0;
      state_d    = RDSEQ_IDLE;
    end

    // Outputs are registered from the next state so they are glitch-free.
    out_valid_d = (state_d == RDSEQ_DONE);
    busy_d      = (state_d != RDSEQ_IDLE);
    rf_r_ena_d  = (state_d == RDSEQ_RD1) | (state_d == RDSEQ_RD2);
    if (state_d == RDSEQ_RD1) begin
      rf_r_addr_d = rs1_addr_d;
    end else if (state_d == RDSEQ_RD2) begin
      rf_r_addr_d = rs2_addr_d;
    end else begin
      rf_r_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RDSEQ_IDLE;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      need1_q     <= 1'b0;
      need2_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_r_ena_q  <= 1'b0;
      rf_r_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      need1_q     <= need1_d;
      need2_q     <= need2_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rf_r_ena_q  <= rf_r_ena_d;
      rf_r_addr_q <= rf_r_addr_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign rf_r_ena  = rf_r_ena_q;
  assign rf_r_addr = rf_r_addr_q;
  assign out_valid = out_valid_q;
  assign op1_src   = op1_q;
  assign op2_src   = op2_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_id_rf_read_seq.sv
// ============================================================================
// Module : tb_id_rf_read_seq
// Brief  : Vector table, directed corner sequences and a queue-based random
//          reference model for id_rf_read_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_rf_read_seq;

  localparam int REG_W  = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              rs1_r_ena, rs2_r_ena;
  logic [ADDR_W-1:0] rs1_r_addr, rs2_r_addr;
  logic              in_ready, rf_r_ena, out_valid, busy;
  logic [ADDR_W-1:0] rf_r_addr;
  logic [REG_W-1:0]  rf_r_data, op1_src, op2_src;
  logic [REG_W-1:0]  regs [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Regfile model is purely combinational; x0 holds garbage so an illegal x0 read shows up.
  assign rf_r_data = regs[rf_r_addr];

  id_rf_read_seq #(.REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rf_r_ena(rf_r_ena), .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1_src(op1_src), .op2_src(op2_src), .busy(busy)
  );

  typedef struct {
    logic       e1;
    logic [4:0] a1;
    logic       e2;
    logic [4:0] a2;
    int         lat;
    int         nrd;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [63:0] op1;
    logic [63:0] op2;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rs1_r_ena  = e1;
    rs1_r_addr = a1;
    rs2_r_ena  = e2;
    rs2_r_addr = a2;
  endtask

  // Issue one instruction from IDLE and wait (bounded) for out_valid, recording port reads.
  task automatic do_txn(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                        output int lat, output int nreads, output logic [4:0] ra0,
                        output logic [4:0] ra1, output logic [63:0] o1, output logic [63:0] o2);
    set_instr(e1, a1, e2, a2);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat    = 1;
    nreads = 0;
    ra0    = '0;
    ra1    = '0;
    while (!out_valid && lat < 8) begin
      if (rf_r_ena) begin
        if (nreads == 0) ra0 = rf_r_addr;
        else ra1 = rf_r_addr;
        nreads++;
      end
      tick();
      lat++;
    end
    o1 = op1_src;
    o2 = op2_src;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready on handshake"}, 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({tag, " busy after handshake"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, nrd;
    logic [4:0] ra0, ra1;
    logic [63:0] o1, o2;
    logic [4:0] rd_q[$];
    bit         m_valid;
    bit         inflight, exp_ready;
    logic [63:0] m_op1, m_op2;

    for (int i = 0; i < 32; i++) regs[i] = {32'hC0DE_0000, 27'd0, 5'(i)};
    regs[0]  = 64'hDEAD_BEEF_DEAD_BEEF;
    regs[3]  = 64'hFF;
    regs[5]  = 64'h11;
    regs[6]  = 64'h22;
    regs[31] = 64'hFFFF_0000_1234_5678;

    vecs[0] = '{1'b1, 5'd5,  1'b1, 5'd6, 3, 2, 5'd5,  5'd6, 64'h11, 64'h22};
    vecs[1] = '{1'b1, 5'd3,  1'b0, 5'd7, 2, 1, 5'd3,  5'd0, 64'hFF, 64'h0};
    vecs[2] = '{1'b1, 5'd0,  1'b1, 5'd0, 1, 0, 5'd0,  5'd0, 64'h0,  64'h0};
    vecs[3] = '{1'b0, 5'd5,  1'b1, 5'd6, 2, 1, 5'd6,  5'd0, 64'h0,  64'h22};
    vecs[4] = '{1'b1, 5'd31, 1'b1, 5'd0, 2, 1, 5'd31, 5'd0, 64'hFFFF_0000_1234_5678, 64'h0};
    vecs[5] = '{1'b1, 5'd6,  1'b1, 5'd6, 3, 2, 5'd6,  5'd6, 64'h22, 64'h22};
    vecs[6] = '{1'b0, 5'd0,  1'b0, 5'd0, 1, 0, 5'd0,  5'd0, 64'h0,  64'h0};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset rf_r_ena", 64'(rf_r_ena), 64'd0);
    check("reset rf_r_addr", 64'(rf_r_addr), 64'd0);
    check("reset op1", op1_src, 64'd0);
    check("reset op2", op2_src, 64'd0);
    rst = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].e1, vecs[i].a1, vecs[i].e2, vecs[i].a2, lat, nrd, ra0, ra1, o1, o2);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d port reads", i), 64'(nrd), 64'(vecs[i].nrd));
      if (vecs[i].nrd > 0) check($sformatf("v%0d first read addr", i), 64'(ra0), 64'(vecs[i].ra0));
      if (vecs[i].nrd > 1) check($sformatf("v%0d second read addr", i), 64'(ra1), 64'(vecs[i].ra1));
      check($sformatf("v%0d op1", i), o1, vecs[i].op1);
      check($sformatf("v%0d op2", i), o2, vecs[i].op2);
      check($sformatf("v%0d rf_r_ena in DONE", i), 64'(rf_r_ena), 64'd0);
      check($sformatf("v%0d in_ready stalled", i), 64'(in_ready), 64'd0);
      release_out($sformatf("v%0d", i));
    end

    // Stall in DONE, then back-to-back accept on the handshake cycle.
    do_txn(1'b1, 5'd5, 1'b1, 5'd6, lat, nrd, ra0, ra1, o1, o2);
    set_instr(1'b1, 5'd3, 1'b0, 5'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d op1", k), op1_src, 64'h11);
      check($sformatf("stall%0d op2", k), op2_src, 64'h22);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("b2b in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b rf_r_ena", 64'(rf_r_ena), 64'd1);
    check("b2b rf_r_addr", 64'(rf_r_addr), 64'd3);
    check("b2b out_valid drops", 64'(out_valid), 64'd0);
    tick();
    check("b2b out_valid", 64'(out_valid), 64'd1);
    check("b2b op1", op1_src, 64'hFF);
    check("b2b op2", op2_src, 64'h0);
    release_out("b2b");

    // Flush while the first source is on the port.
    set_instr(1'b1, 5'd5, 1'b1, 5'd6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("flush pre rf_r_addr", 64'(rf_r_addr), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush op1", op1_src, 64'd0);
    check("flush rf_r_ena", 64'(rf_r_ena), 64'd0);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush blocks accept", 64'(busy), 64'd0);
    do_txn(1'b1, 5'd3, 1'b0, 5'd0, lat, nrd, ra0, ra1, o1, o2);
    check("post-flush latency", 64'(lat), 64'd2);
    check("post-flush op1", o1, 64'hFF);
    release_out("post-flush");

    // Reset in RD2, after op1 is already latched.
    set_instr(1'b1, 5'd5, 1'b1, 5'd6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rd2 op1 latched", op1_src, 64'h11);
    check("rd2 rf_r_addr", 64'(rf_r_addr), 64'd6);
    rst = 1'b0;
    tick();
    check("midrst op1", op1_src, 64'd0);
    check("midrst op2", op2_src, 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst rf_r_ena", 64'(rf_r_ena), 64'd0);
    check("midrst rf_r_addr", 64'(rf_r_addr), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst in_ready", 64'(in_ready), 64'd1);

    // Random traffic against a queue-of-pending-reads reference model.
    for (int i = 1; i < 32; i++) regs[i] = {$urandom, $urandom};
    m_valid = 1'b0;
    m_op1   = '0;
    m_op2   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      rs1_r_ena  = $urandom_range(0, 1) != 0;
      rs2_r_ena  = $urandom_range(0, 1) != 0;
      rs1_r_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs2_r_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      #1;
      inflight  = (rd_q.size() != 0) || m_valid;
      exp_ready = !inflight || (m_valid && out_ready);
      check("rnd in_ready", 64'(in_ready), 64'(exp_ready));
      check("rnd out_valid", 64'(out_valid), 64'(m_valid));
      check("rnd busy", 64'(busy), 64'(inflight));
      check("rnd rf_r_ena", 64'(rf_r_ena), 64'(rd_q.size() != 0));
      if (rd_q.size() != 0) check("rnd rf_r_addr", 64'(rf_r_addr), 64'(rd_q[0]));
      else check("rnd rf_r_addr idle", 64'(rf_r_addr), 64'd0);
      if (m_valid) begin
        check("rnd op1", op1_src, m_op1);
        check("rnd op2", op2_src, m_op2);
      end

      if (flush) begin
        rd_q.delete();
        m_valid = 1'b0;
      end else begin
        if (rd_q.size() != 0) begin
          void'(rd_q.pop_front());
          if (rd_q.size() == 0) m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (in_valid && exp_ready) begin
          m_op1 = (rs1_r_ena && rs1_r_addr != 0) ? regs[rs1_r_addr] : 64'd0;
          m_op2 = (rs2_r_ena && rs2_r_addr != 0) ? regs[rs2_r_addr] : 64'd0;
          if (rs1_r_ena && rs1_r_addr != 0) rd_q.push_back(rs1_r_addr);
          if (rs2_r_ena && rs2_r_addr != 0) rd_q.push_back(rs2_r_addr);
          m_valid = (rd_q.size() == 0);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
